// File: rtl/uart_tx_io.sv
// Memory-mapped 8N1 UART transmitter on the CPU I/O bus: a byte-lane register window,
// a small TX FIFO and a frame serialiser with a programmable bit period.
module uart_tx_io #(
  parameter logic [15:0] ADDRBASE    = 16'h0010,
  parameter int          FIFODEPTH   = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd104
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] dread_addr,
  output logic [15:0] dread_data,
  input  logic [15:0] dwrite_addr,
  input  logic [15:0] dwrite_data,
  input  logic [1:0]  dwrite_en,
  output logic        txd,
  output logic        irq
);

  localparam int PW = (FIFODEPTH > 1) ? $clog2(FIFODEPTH) : 1;
  localparam int CW = $clog2(FIFODEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFODEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state;
  logic [7:0]    fifo_mem [FIFODEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          overflow;
  logic          ien;
  logic [15:0]   divisor;
  logic [7:0]    shreg;
  logic [15:0]   eff_div;
  logic [15:0]   baud;
  logic [2:0]    bit_idx;

  logic          full;
  logic          empty;
  logic          busy;
  logic          pop;
  logic          push;
  logic          push_ok;
  logic          push_drop;
  logic [7:0]    push_data;
  logic          status_wr;
  logic [7:0]    status_data;
  logic          div_lo_wr;
  logic [7:0]    div_lo;
  logic          div_hi_wr;
  logic [7:0]    div_hi;
  logic [15:0]   eff_next;
  logic [7:0]    status_byte;

  logic [15:0]   lane_addr [2];
  logic [7:0]    lane_byte [2];
  logic [1:0]    lane_off  [2];
  logic [1:0]    lane_hit;

  function automatic logic in_window(input logic [15:0] a);
    logic [15:0] rel;
    rel = a - ADDRBASE;
    return (rel < 16'd4);
  endfunction

  function automatic logic [1:0] reg_offset(input logic [15:0] a);
    logic [15:0] rel;
    rel = a - ADDRBASE;
    return rel[1:0];
  endfunction

  function automatic logic [7:0] read_byte(input logic [15:0] a, input logic [7:0] status,
                                           input logic [15:0] div);
    logic [7:0] rb;
    if (!in_window(a)) begin
      rb = 8'h00;
    end else begin
      case (reg_offset(a))
        2'd0:    rb = 8'h00;
        2'd1:    rb = status;
        2'd2:    rb = div[7:0];
        2'd3:    rb = div[15:8];
        default: rb = 8'h00;
      endcase
    end
    return rb;
  endfunction

  assign full        = (count == FULL_CNT);
  assign empty       = (count == {CW{1'b0}});
  assign busy        = (state != IDLE);
  assign irq         = ien & empty & ~busy;
  assign status_byte = {ien, 3'b000, overflow, busy, empty, full};
  assign eff_next    = (divisor == 16'd0) ? 16'd1 : divisor;
  assign pop         = ~empty & ((state == IDLE) | ((state == STOP) & (baud == 16'd0)));
  assign push_ok     = push & ~full;
  assign push_drop   = push & full;

  assign lane_addr[0] = dwrite_addr;
  assign lane_addr[1] = dwrite_addr + 16'd1;
  assign lane_byte[0] = dwrite_data[7:0];
  assign lane_byte[1] = dwrite_data[15:8];
  assign lane_off[0]  = reg_offset(lane_addr[0]);
  assign lane_off[1]  = reg_offset(lane_addr[1]);
  assign lane_hit[0]  = dwrite_en[0] & in_window(lane_addr[0]);
  assign lane_hit[1]  = dwrite_en[1] & in_window(lane_addr[1]);

  // Route each enabled byte lane to the register its own address selects.
  always_comb begin
    push        = 1'b0;
    push_data   = 8'h00;
    status_wr   = 1'b0;
    status_data = 8'h00;
    div_lo_wr   = 1'b0;
    div_lo      = 8'h00;
    div_hi_wr   = 1'b0;
    div_hi      = 8'h00;
    for (int i = 0; i < 2; i++) begin
      case ({lane_hit[i], lane_off[i]})
        3'b100: begin push = 1'b1;      push_data   = lane_byte[i]; end
        3'b101: begin status_wr = 1'b1; status_data = lane_byte[i]; end
        3'b110: begin div_lo_wr = 1'b1; div_lo      = lane_byte[i]; end
        3'b111: begin div_hi_wr = 1'b1; div_hi      = lane_byte[i]; end
        default: ;
      endcase
    end
  end

  // FIFO storage; contents are don't-care once the pointers are reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr] <= push_data;
    end
  end

  // FIFO pointers/count and the control registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= {PW{1'b0}};
      rd_ptr   <= {PW{1'b0}};
      count    <= {CW{1'b0}};
      overflow <= 1'b0;
      ien      <= 1'b0;
      divisor  <= DEFAULT_DIV;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + {{(PW-1){1'b0}}, 1'b1};
      end
      if (pop) begin
        rd_ptr <= rd_ptr + {{(PW-1){1'b0}}, 1'b1};
      end
      case ({push_ok, pop})
        2'b10:   count <= count + {{(CW-1){1'b0}}, 1'b1};
        2'b01:   count <= count - {{(CW-1){1'b0}}, 1'b1};
        default: count <= count;
      endcase
      // A drop in the same cycle as a clear request leaves the flag set.
      if (push_drop) begin
        overflow <= 1'b1;
      end else if (status_wr && status_data[3]) begin
        overflow <= 1'b0;
      end
      if (status_wr) begin
        ien <= status_data[7];
      end
      if (div_lo_wr) begin
        divisor[7:0] <= div_lo;
      end
      if (div_hi_wr) begin
        divisor[15:8] <= div_hi;
      end
    end
  end

  // Frame serialiser; a frame is 10 bit slots of eff_div clocks each.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      txd     <= 1'b1;
      shreg   <= 8'h00;
      eff_div <= 16'd1;
      baud    <= 16'd0;
      bit_idx <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            state   <= START;
            txd     <= 1'b0;
            shreg   <= fifo_mem[rd_ptr];
            eff_div <= eff_next;
            baud    <= eff_next - 16'd1;
          end else begin
            txd <= 1'b1;
          end
        end
        START: begin
          if (baud == 16'd0) begin
            state   <= DATA;
            txd     <= shreg[0];
            shreg   <= {1'b0, shreg[7:1]};
            bit_idx <= 3'd0;
            baud    <= eff_div - 16'd1;
          end else begin
            baud <= baud - 16'd1;
          end
        end
        DATA: begin
          if (baud == 16'd0) begin
            baud <= eff_div - 16'd1;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              txd   <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              txd     <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
            end
          end else begin
            baud <= baud - 16'd1;
          end
        end
        STOP: begin
          if (baud == 16'd0) begin
            // Chain straight into the next start bit when more data is queued.
            if (pop) begin
              state   <= START;
              txd     <= 1'b0;
              shreg   <= fifo_mem[rd_ptr];
              eff_div <= eff_next;
              baud    <= eff_next - 16'd1;
            end else begin
              state <= IDLE;
              txd   <= 1'b1;
            end
          end else begin
            baud <= baud - 16'd1;
          end
        end
        default: begin
          state <= IDLE;
          txd   <= 1'b1;
        end
      endcase
    end
  end

  // Registered read path: each lane returns pre-edge register contents.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dread_data <= 16'h0000;
    end else begin
      dread_data <= {read_byte(dread_addr + 16'd1, status_byte, divisor),
                     read_byte(dread_addr, status_byte, divisor)};
    end
  end

endmodule

// File: tb/tb_uart_tx_io.sv
// Randomised bench for uart_tx_io: a queue-based frame model predicts txd, irq and
// read data every clock.
module tb_uart_tx_io;

  localparam logic [15:0] BASE  = 16'h0010;
  localparam int          DEPTH = 4;
  localparam logic [15:0] DDIV  = 16'd104;

  logic        clk;
  logic        reset;
  logic [15:0] dread_addr;
  logic [15:0] dread_data;
  logic [15:0] dwrite_addr;
  logic [15:0] dwrite_data;
  logic [1:0]  dwrite_en;
  logic        txd;
  logic        irq;

  uart_tx_io #(.ADDRBASE(BASE), .FIFODEPTH(DEPTH), .DEFAULT_DIV(DDIV)) dut (
    .clk(clk), .reset(reset),
    .dread_addr(dread_addr), .dread_data(dread_data),
    .dwrite_addr(dwrite_addr), .dwrite_data(dwrite_data), .dwrite_en(dwrite_en),
    .txd(txd), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model: queued bytes plus the frame currently on the line.
  logic [7:0]  m_q[$];
  logic        m_ovf;
  logic        m_ien;
  logic [15:0] m_div;
  logic        m_active;
  int          m_t;
  int          m_fdiv;
  logic [7:0]  m_byte;
  logic [15:0] exp_rd;
  logic        ien_phase;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ovf = 1'b0; m_ien = 1'b0; m_div = DDIV;
    m_active = 1'b0; m_t = 0; m_fdiv = 1; m_byte = 8'h00;
  endtask

  function automatic logic [7:0] m_read(input logic [15:0] a);
    logic [15:0] rel;
    rel = a - BASE;
    if (rel >= 16'd4) return 8'h00;
    case (rel[1:0])
      2'd1:    return {m_ien, 3'b000, m_ovf, m_active, (m_q.size() == 0), (m_q.size() == DEPTH)};
      2'd2:    return m_div[7:0];
      2'd3:    return m_div[15:8];
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic m_txd();
    int slot;
    if (!m_active) return 1'b1;
    slot = m_t / m_fdiv;
    if (slot == 0) return 1'b0;
    if (slot >= 9) return 1'b1;
    return m_byte[slot-1];
  endfunction

  task automatic model_step(input logic [1:0] en, input logic [15:0] wa, input logic [15:0] wd,
                            input logic [15:0] ra);
    int pre_size;
    logic set_ovf, clr_ovf;
    logic [15:0] la, rel;
    logic [7:0] b;
    exp_rd = {m_read(ra + 16'd1), m_read(ra)};
    pre_size = m_q.size();
    if (m_active) begin
      m_t++;
      if (m_t == 10 * m_fdiv) m_active = 1'b0;
    end
    if (!m_active && pre_size > 0) begin
      m_byte = m_q.pop_front();
      m_fdiv = (m_div == 16'd0) ? 1 : int'(m_div);
      m_t = 0;
      m_active = 1'b1;
    end
    set_ovf = 1'b0; clr_ovf = 1'b0;
    for (int i = 0; i < 2; i++) begin
      la = wa + 16'(i);
      rel = la - BASE;
      b = wd[8*i +: 8];
      if (en[i] && rel < 16'd4) begin
        case (rel[1:0])
          2'd0: if (pre_size == DEPTH) set_ovf = 1'b1; else m_q.push_back(b);
          2'd1: begin clr_ovf = b[3]; m_ien = b[7]; end
          2'd2: m_div[7:0] = b;
          default: m_div[15:8] = b;
        endcase
      end
    end
    if (set_ovf) m_ovf = 1'b1;
    else if (clr_ovf) m_ovf = 1'b0;
  endtask

  task automatic cycle(input logic [1:0] en, input logic [15:0] wa, input logic [15:0] wd,
                       input logic [15:0] ra);
    dwrite_en = en; dwrite_addr = wa; dwrite_data = wd; dread_addr = ra;
    @(posedge clk);
    #1;
    model_step(en, wa, wd, ra);
    check_eq("txd", {15'd0, txd}, {15'd0, m_txd()});
    check_eq("irq", {15'd0, irq}, {15'd0, m_ien && (m_q.size() == 0) && !m_active});
    check_eq("dread_data", dread_data, exp_rd);
  endtask

  // Random writes near the window; STATUS bit7 follows ien_phase and the divisor stays below 8.
  task automatic run_random(input int n, input int pct);
    logic [1:0] en;
    logic [15:0] wa, wd, rel;
    logic [7:0] b;
    for (int k = 0; k < n; k++) begin
      en = ($urandom_range(0, 99) < pct) ? 2'($urandom_range(1, 3)) : 2'b00;
      wa = BASE - 16'd2 + 16'($urandom_range(0, 6));
      wd = 16'($urandom);
      for (int i = 0; i < 2; i++) begin
        rel = wa + 16'(i) - BASE;
        b = wd[8*i +: 8];
        if (rel < 16'd4) begin
          case (rel[1:0])
            2'd1:    b = {ien_phase, b[6:0]};
            2'd2:    b = b & 8'h07;
            2'd3:    b = 8'h00;
            default: b = b;
          endcase
        end
        wd[8*i +: 8] = b;
      end
      cycle(en, wa, wd, BASE - 16'd2 + 16'($urandom_range(0, 6)));
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    dwrite_en = 2'b00; dwrite_addr = 16'h0000; dwrite_data = 16'h0000; dread_addr = 16'h0000;
    #1;
    check_eq("rst_txd", {15'd0, txd}, 16'h0001);
    check_eq("rst_dread", dread_data, 16'h0000);
    check_eq("rst_irq", {15'd0, irq}, 16'h0000);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    ien_phase = 1'b0;
  endtask

  initial begin
    int guard;
    ien_phase = 1'b0;
    model_reset();
    do_reset();
    cycle(2'b00, 16'h0000, 16'h0000, BASE + 16'd2);
    check_eq("div_reset", dread_data, 16'h0068);
    cycle(2'b00, 16'h0000, 16'h0000, BASE + 16'd1);
    check_eq("status_reset", dread_data, 16'h6802);
    cycle(2'b11, BASE + 16'd2, 16'h0003, BASE + 16'd2);
    cycle(2'b11, BASE - 16'd1, 16'h3C00, BASE + 16'd3);
    run_random(800, 10);
    run_random(600, 50);
    ien_phase = 1'b1;
    cycle(2'b01, BASE + 16'd1, 16'h0080, BASE + 16'd1);
    run_random(600, 3);
    run_random(600, 40);
    guard = 0;
    while (!m_active && guard < 500) begin
      cycle(2'b01, BASE, 16'h005A, BASE + 16'd1);
      guard++;
    end
    check_eq("frame_before_reset", {15'd0, m_active}, 16'h0001);
    #2;
    do_reset();
    cycle(2'b00, 16'h0000, 16'h0000, BASE + 16'd1);
    check_eq("status_after_reset", dread_data, 16'h6802);
    cycle(2'b11, BASE + 16'd2, 16'h0000, BASE);
    run_random(800, 30);
    ien_phase = 1'b1;
    run_random(500, 5);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
